// File: rtl/static_cfg_seq_pkg.sv
// rtl/static_cfg_seq_pkg.sv - shared types and helpers for the static config sequencer
//
// Purpose : FSM state encoding, index-width helper and field parity function
//           used by static_cfg_seq, static_cfg_field and static_cfg_seq_if.
package static_cfg_seq_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOAD   = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even-parity bit: the stored bit makes data+parity hold an even number of ones.
  // Callers zero-extend the field, so fields up to 64 bits are covered.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/static_cfg_seq_if.sv
// rtl/static_cfg_seq_if.sv - bus bundle between the config sequencer and its users
//
// Purpose : groups tie-off inputs, reload handshake, captured outputs, status
//           and the indexed read port.
// Modports: slave  - the sequencer (drives captured values, status, read data)
//           master - the surrounding logic (drives tie-offs, reload_req, reads)
interface static_cfg_seq_if #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 8
);
  localparam int IDX_W = static_cfg_seq_pkg::idx_width(NUM_FIELDS);

  logic [NUM_FIELDS*FIELD_W-1:0] static_i;
  logic                          reload_req;
  logic                          reload_ack;
  logic [NUM_FIELDS*FIELD_W-1:0] static_o;
  logic                          static_valid;
  logic                          busy;
  logic                          rd_en;
  logic [IDX_W-1:0]              rd_idx;
  logic [FIELD_W-1:0]            rd_data;
  logic                          rd_valid;
  logic                          parity_err;

  modport slave (
    input  static_i, reload_req, rd_en, rd_idx,
    output reload_ack, static_o, static_valid, busy, rd_data, rd_valid, parity_err
  );

  modport master (
    output static_i, reload_req, rd_en, rd_idx,
    input  reload_ack, static_o, static_valid, busy, rd_data, rd_valid, parity_err
  );

endinterface

// File: rtl/static_cfg_field.sv
// rtl/static_cfg_field.sv - one captured configuration field with optional parity guard
//
// Purpose : FIELD_W holding register loaded on i_load. With
//           STATIC_CFG_SEQ_PARITY_EN defined it also stores an even-parity bit
//           taken from i_d at capture and flags (sticky) any disagreement
//           between stored data and stored parity while i_chk_en is high.
// Ports   : clk, reset  - clock, asynchronous active-high reset
//           i_load      - capture i_d this cycle
//           i_d         - tie-off slice for this field
//           i_chk_en    - parity check enable (sequencer in DONE)
//           i_clr_err   - clear the sticky error (entry to SETTLE)
//           o_q         - captured value
//           o_perr      - sticky parity error, 0 without the macro
module static_cfg_field
  import static_cfg_seq_pkg::*;
#(
  parameter int FIELD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [FIELD_W-1:0] i_d,
  input  logic               i_chk_en,
  input  logic               i_clr_err,
  output logic [FIELD_W-1:0] o_q,
  output logic               o_perr
);

  logic [FIELD_W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

`ifdef STATIC_CFG_SEQ_PARITY_EN
  logic r_par;
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (i_load) begin
      r_par <= even_par(64'(i_d));
    end
  end

  // Clear wins over a same-cycle detection so a fresh SETTLE starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (i_clr_err) begin
      r_err <= 1'b0;
    end else if (i_chk_en && (even_par(64'(r_q)) != r_par)) begin
      r_err <= 1'b1;
    end
  end

  assign o_perr = r_err;
`else
  logic w_unused;
  assign w_unused = i_chk_en ^ i_clr_err;
  assign o_perr   = 1'b0;
`endif

endmodule

// File: rtl/static_cfg_seq.sv
// rtl/static_cfg_seq.sv - settle/capture sequencer for ECO-alterable static config fields
//
// Purpose : after reset (or an accepted reload) waits SETTLE_CYCLES, captures
//           one field per cycle into holding registers, then reports the bank
//           valid. Reloads use a level req / one-cycle ack handshake. A
//           registered indexed read port serves ID/ROM-table logic.
// Ports   : clk   - clock
//           reset - asynchronous active-high reset
//           bus   - static_cfg_seq_if.slave: static_i, reload_req/ack,
//                   static_o, static_valid, busy, rd_en/rd_idx/rd_data/rd_valid,
//                   parity_err
// Option  : STATIC_CFG_SEQ_PARITY_EN enables per-field parity storage/checking.
module static_cfg_seq
  import static_cfg_seq_pkg::*;
#(
  parameter int NUM_FIELDS    = 4,
  parameter int FIELD_W       = 8,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  static_cfg_seq_if.slave bus
);

  localparam int IDX_W    = idx_width(NUM_FIELDS);
  localparam int CNT_W    = idx_width(SETTLE_CYCLES);
  localparam int RD_DEPTH = 1 << IDX_W;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_pend;
  logic               r_ack;
  logic [FIELD_W-1:0] r_rd_data;
  logic               r_rd_valid;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_pend_nxt;
  logic               w_ack_nxt;
  logic               w_load;
  logic               w_clr_err;
  logic               w_chk_en;

  logic [FIELD_W-1:0]    w_field  [NUM_FIELDS];
  logic [FIELD_W-1:0]    w_rd_tbl [RD_DEPTH];
  logic [NUM_FIELDS-1:0] w_perr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SETTLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // r_pend marks a load started by a reload request, so only that load acks.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend;
    w_ack_nxt   = 1'b0;
    w_load      = 1'b0;
    w_clr_err   = 1'b0;
    case (r_state)
      SETTLE: begin
        // SETTLE_CYCLES of 0 or 1 both leave after a single cycle.
        if (SETTLE_CYCLES <= 1 || r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOAD: begin
        w_load = 1'b1;
        if (r_idx == IDX_W'(NUM_FIELDS - 1)) begin
          w_state_nxt = DONE;
          w_idx_nxt   = '0;
          w_ack_nxt   = r_pend;
          w_pend_nxt  = 1'b0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        // The ack cycle still sees the old request level; only a level that
        // survives past the ack counts as a new request.
        if (!r_ack && bus.reload_req) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b1;
          w_clr_err   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_chk_en = (r_state == DONE);

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    static_cfg_field #(
      .FIELD_W(FIELD_W)
    ) u_field (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load && (r_idx == IDX_W'(k))),
      .i_d      (bus.static_i[k*FIELD_W +: FIELD_W]),
      .i_chk_en (w_chk_en),
      .i_clr_err(w_clr_err),
      .o_q      (w_field[k]),
      .o_perr   (w_perr[k])
    );
    assign bus.static_o[k*FIELD_W +: FIELD_W] = w_field[k];
  end

  // Read table padded to the full index range; unused indices read as zero.
  for (genvar k = 0; k < RD_DEPTH; k++) begin : g_rd_tbl
    if (k < NUM_FIELDS) begin : g_used
      assign w_rd_tbl[k] = w_field[k];
    end else begin : g_pad
      assign w_rd_tbl[k] = '0;
    end
  end

  // Reads the field registers before this edge's capture lands, so a read
  // that collides with a capture returns the previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_tbl[bus.rd_idx];
      end
    end
  end

  assign bus.reload_ack   = r_ack;
  assign bus.static_valid = (r_state == DONE);
  assign bus.busy         = (r_state != DONE);
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.parity_err   = |w_perr;

endmodule
